// File: rtl/uart_cmd_parser.sv
// Frames UART bytes into SYNC/CMD/ADDR/DATA/CSUM commands, checks the 8-bit checksum, aborts on inter-byte timeout.
// Optional ACK/NAK response path enabled by defining UART_CMD_ACK_EN.
module uart_cmd_parser #(
  parameter int          DATA_BYTES   = 4,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int          TIMEOUT_CLKS = 50000
) (
  input  logic                    i_sys_clk,
  input  logic                    i_rst,
  input  logic                    i_Rx_DV,
  input  logic [7:0]              i_Rx_Byte,
`ifdef UART_CMD_ACK_EN
  input  logic                    i_Tx_Active,
  output logic                    o_Tx_DV,
  output logic [7:0]              o_Tx_Byte,
`endif
  output logic                    o_Cmd_Valid,
  output logic [7:0]              o_Cmd,
  output logic [7:0]              o_Addr,
  output logic [8*DATA_BYTES-1:0] o_Data,
  output logic                    o_Csum_Err,
  output logic                    o_Timeout,
  output logic                    o_Busy
);

  localparam int IDX_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BYTES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_CSUM} state_t;

  state_t                  state_q;
  logic [7:0]              sum_q, sh_cmd_q, sh_addr_q, cmd_q, addr_q;
  logic [8*DATA_BYTES-1:0] sh_data_q, data_q;
  logic [IDX_W-1:0]        idx_q;
  logic [CNT_W-1:0]        gap_q;
  logic                    cmd_vld_q, csum_err_q, timeout_q;

  logic [7:0]       sum_d;
  logic [CNT_W-1:0] gap_d;

  assign sum_d = sum_q + i_Rx_Byte;
  assign gap_d = gap_q + CNT_W'(1);

  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      sum_q      <= '0;
      sh_cmd_q   <= '0;
      sh_addr_q  <= '0;
      sh_data_q  <= '0;
      cmd_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      idx_q      <= '0;
      gap_q      <= '0;
      cmd_vld_q  <= 1'b0;
      csum_err_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      cmd_vld_q  <= 1'b0;
      csum_err_q <= 1'b0;
      timeout_q  <= 1'b0;
      gap_q      <= (state_q == S_IDLE || i_Rx_DV) ? '0 : gap_d;
      case (state_q)
        S_IDLE: if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) begin
          sum_q   <= '0;
          state_q <= S_CMD;
        end
        S_CMD: if (i_Rx_DV) begin
          sh_cmd_q <= i_Rx_Byte;
          sum_q    <= sum_d;
          state_q  <= S_ADDR;
        end
        S_ADDR: if (i_Rx_DV) begin
          sh_addr_q <= i_Rx_Byte;
          sum_q     <= sum_d;
          idx_q     <= '0;
          state_q   <= S_DATA;
        end
        S_DATA: if (i_Rx_DV) begin
          sh_data_q[{idx_q, 3'b000} +: 8] <= i_Rx_Byte;
          sum_q <= sum_d;
          idx_q <= idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) state_q <= S_CSUM;
        end
        S_CSUM: if (i_Rx_DV) begin
          if (sum_d == 8'h00) begin
            cmd_q     <= sh_cmd_q;
            addr_q    <= sh_addr_q;
            data_q    <= sh_data_q;
            cmd_vld_q <= 1'b1;
          end else begin
            csum_err_q <= 1'b1;
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      // A byte on the terminal-count cycle wins, so only abort when the line is quiet.
      if (state_q != S_IDLE && !i_Rx_DV && gap_d == GAP_LAST) begin
        state_q   <= S_IDLE;
        timeout_q <= 1'b1;
      end
    end
  end

  assign o_Cmd_Valid = cmd_vld_q;
  assign o_Csum_Err  = csum_err_q;
  assign o_Timeout   = timeout_q;
  assign o_Cmd       = cmd_q;
  assign o_Addr      = addr_q;
  assign o_Data      = data_q;
  assign o_Busy      = (state_q != S_IDLE);

`ifdef UART_CMD_ACK_EN
  logic       pend_q, tx_dv_q;
  logic [7:0] resp_q, tx_byte_q;

  // Single response slot: a fresh verdict overwrites one still waiting for the transmitter.
  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      pend_q    <= 1'b0;
      resp_q    <= '0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= '0;
    end else begin
      tx_dv_q <= 1'b0;
      if (pend_q && !i_Tx_Active) begin
        tx_dv_q   <= 1'b1;
        tx_byte_q <= resp_q;
        pend_q    <= 1'b0;
      end
      if (cmd_vld_q) begin
        pend_q <= 1'b1;
        resp_q <= 8'h06;
      end else if (csum_err_q) begin
        pend_q <= 1'b1;
        resp_q <= 8'h15;
      end
    end
  end

  assign o_Tx_DV   = tx_dv_q;
  assign o_Tx_Byte = tx_byte_q;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser (DATA_BYTES=4, TIMEOUT_CLKS=100); ACK test runs when UART_CMD_ACK_EN is defined.
module tb_uart_cmd_parser;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        cmd_valid, csum_err, timeout, busy;
  logic [7:0]  cmd, addr;
  logic [31:0] data;
`ifdef UART_CMD_ACK_EN
  logic        tx_active = 1'b0;
  logic        tx_dv;
  logic [7:0]  tx_byte;
`endif

  int checks = 0;
  int errors = 0;
  int n_cv = 0, n_ce = 0, n_to = 0, n_tx = 0;

  always #5 clk = ~clk;

  uart_cmd_parser #(.DATA_BYTES(4), .SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(100)) dut (
    .i_sys_clk   (clk),
    .i_rst       (rst),
    .i_Rx_DV     (rx_dv),
    .i_Rx_Byte   (rx_byte),
`ifdef UART_CMD_ACK_EN
    .i_Tx_Active (tx_active),
    .o_Tx_DV     (tx_dv),
    .o_Tx_Byte   (tx_byte),
`endif
    .o_Cmd_Valid (cmd_valid),
    .o_Cmd       (cmd),
    .o_Addr      (addr),
    .o_Data      (data),
    .o_Csum_Err  (csum_err),
    .o_Timeout   (timeout),
    .o_Busy      (busy)
  );

  always @(negedge clk) begin
    if (cmd_valid === 1'b1) n_cv++;
    if (csum_err === 1'b1) n_ce++;
    if (timeout === 1'b1) n_to++;
`ifdef UART_CMD_ACK_EN
    if (tx_dv === 1'b1) n_tx++;
`endif
  end

  task send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_dv = 1'b1;
    rx_byte = b;
  endtask

  task end_burst();
    @(negedge clk);
    rx_dv = 1'b0;
    rx_byte = 8'h00;
  endtask

  task send_frame(input logic [7:0] c, input logic [7:0] a, input logic [31:0] d,
                  input logic [7:0] cs, input bit last);
    send_byte(8'hA5);
    send_byte(c);
    send_byte(a);
    send_byte(d[7:0]);
    send_byte(d[15:8]);
    send_byte(d[23:16]);
    send_byte(d[31:24]);
    send_byte(cs);
    if (last) end_burst();
  endtask

  task test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_valid, csum_err, timeout, busy} !== 4'b0000 || cmd !== 8'h00 || addr !== 8'h00 || data !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got strobes=%b busy=%b cmd=%h addr=%h data=%h, need all zero",
               {cmd_valid, csum_err, timeout}, busy, cmd, addr, data);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy=%b need 0", busy); end
  endtask

  task test_good();
    int cv0;
    cv0 = n_cv;
    send_frame(8'h01, 8'h10, 32'hDEADBEEF, 8'hB7, 1);
    checks++;
    if (cmd_valid !== 1'b1 || csum_err !== 1'b0) begin
      errors++; $display("FAIL good_strobe: cmd_valid=%b csum_err=%b need 1/0", cmd_valid, csum_err);
    end
    checks++;
    if (cmd !== 8'h01 || addr !== 8'h10 || data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL good_fields: cmd=%h addr=%h data=%h need 01 10 deadbeef", cmd, addr, data);
    end
    @(negedge clk); #1;
    checks++;
    if (cmd_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL good_after: cmd_valid=%b busy=%b need 0/0", cmd_valid, busy);
    end
    checks++;
    if (n_cv - cv0 != 1) begin errors++; $display("FAIL good_count: pulses=%0d need 1", n_cv - cv0); end
  endtask

  task test_csum_err();
    int cv0, ce0;
    cv0 = n_cv; ce0 = n_ce;
    send_frame(8'h02, 8'h20, 32'h44332211, 8'h35, 1);
    checks++;
    if (csum_err !== 1'b1 || cmd_valid !== 1'b0) begin
      errors++; $display("FAIL csum_strobe: csum_err=%b cmd_valid=%b need 1/0", csum_err, cmd_valid);
    end
    checks++;
    if (cmd !== 8'h01 || addr !== 8'h10 || data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL csum_hold: cmd=%h addr=%h data=%h need 01 10 deadbeef", cmd, addr, data);
    end
    send_frame(8'h01, 8'h10, 32'hDEADBEEF, 8'hB8, 1);
    checks++;
    if (csum_err !== 1'b1 || cmd_valid !== 1'b0) begin
      errors++; $display("FAIL csum_b8: csum_err=%b cmd_valid=%b need 1/0", csum_err, cmd_valid);
    end
    repeat (3) @(negedge clk); #1;
    checks++;
    if (n_ce - ce0 != 2 || n_cv - cv0 != 0) begin
      errors++; $display("FAIL csum_count: err=%0d valid=%0d need 2/0", n_ce - ce0, n_cv - cv0);
    end
`ifdef UART_CMD_ACK_EN
    checks++;
    if (tx_byte !== 8'h15) begin errors++; $display("FAIL nak_byte: tx_byte=%h need 15", tx_byte); end
`endif
  endtask

  task test_noise();
    int cv0;
    cv0 = n_cv;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    end_burst();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL noise_idle: busy=%b need 0", busy); end
    send_frame(8'h02, 8'h20, 32'h44332211, 8'h34, 1);
    checks++;
    if (cmd_valid !== 1'b1 || cmd !== 8'h02 || addr !== 8'h20 || data !== 32'h44332211) begin
      errors++; $display("FAIL noise_frame: valid=%b cmd=%h addr=%h data=%h need 1 02 20 44332211",
                         cmd_valid, cmd, addr, data);
    end
    @(negedge clk); #1;
    checks++;
    if (n_cv - cv0 != 1) begin errors++; $display("FAIL noise_count: pulses=%0d need 1", n_cv - cv0); end
  endtask

  task test_timeout();
    int bad;
    bad = 0;
    send_byte(8'hA5);
    send_byte(8'h01);
    end_burst();
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (timeout !== (k == 99)) bad++;
      if (k == 99) begin
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL timeout_idle: busy=%b need 0", busy); end
      end
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL timeout_cycle: %0d wrong cycles, need pulse only at cycle 99", bad); end
    send_frame(8'h01, 8'h10, 32'hDEADBEEF, 8'hB7, 1);
    checks++;
    if (cmd_valid !== 1'b1 || data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL timeout_next: valid=%b data=%h need 1 deadbeef", cmd_valid, data);
    end
  endtask

  task test_timeout_boundary();
    int to0;
    to0 = n_to;
    send_byte(8'hA5);
    end_burst();
    repeat (97) @(negedge clk);
    send_byte(8'h02);
    send_byte(8'h20); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h34);
    end_burst();
    checks++;
    if (cmd_valid !== 1'b1 || cmd !== 8'h02 || data !== 32'h44332211) begin
      errors++; $display("FAIL byte_wins: valid=%b cmd=%h data=%h need 1 02 44332211", cmd_valid, cmd, data);
    end
    @(negedge clk); #1;
    checks++;
    if (n_to != to0) begin errors++; $display("FAIL byte_wins_to: timeouts=%0d need 0", n_to - to0); end
  endtask

  task test_mid_reset();
    int cv0, ce0, to0;
    cv0 = n_cv; ce0 = n_ce; to0 = n_to;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10); send_byte(8'hEF);
    end_burst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || cmd !== 8'h00 || data !== 32'h0) begin
      errors++; $display("FAIL midrst_clear: busy=%b cmd=%h data=%h need 0 00 0", busy, cmd, data);
    end
    send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE); send_byte(8'hB7);
    end_burst();
    repeat (3) @(negedge clk); #1;
    checks++;
    if (n_cv != cv0 || n_ce != ce0 || n_to != to0) begin
      errors++; $display("FAIL midrst_strobes: valid=%0d err=%0d to=%0d need 0/0/0",
                         n_cv - cv0, n_ce - ce0, n_to - to0);
    end
    send_frame(8'h01, 8'h10, 32'hDEADBEEF, 8'hB7, 1);
    checks++;
    if (cmd_valid !== 1'b1 || cmd !== 8'h01 || addr !== 8'h10 || data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL midrst_next: valid=%b cmd=%h addr=%h data=%h", cmd_valid, cmd, addr, data);
    end
  endtask

  task test_back_to_back();
    int cv0;
    @(negedge clk); #1;
    cv0 = n_cv;
    send_frame(8'h01, 8'h10, 32'hDEADBEEF, 8'hB7, 0);
    send_frame(8'h02, 8'h20, 32'h44332211, 8'h34, 1);
    checks++;
    if (cmd_valid !== 1'b1 || cmd !== 8'h02 || addr !== 8'h20 || data !== 32'h44332211) begin
      errors++; $display("FAIL b2b_fields: valid=%b cmd=%h addr=%h data=%h need 1 02 20 44332211",
                         cmd_valid, cmd, addr, data);
    end
    @(negedge clk); #1;
    checks++;
    if (n_cv - cv0 != 2 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_count: pulses=%0d busy=%b need 2/0", n_cv - cv0, busy);
    end
  endtask

`ifdef UART_CMD_ACK_EN
  task test_ack();
    int tx0;
    @(negedge clk); #1;
    tx0 = n_tx;
    tx_active = 1'b1;
    send_frame(8'h01, 8'h10, 32'hDEADBEEF, 8'hB7, 1);
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (n_tx != tx0) begin errors++; $display("FAIL ack_hold: tx pulses=%0d need 0", n_tx - tx0); end
    tx_active = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_dv !== 1'b1 || tx_byte !== 8'h06) begin
      errors++; $display("FAIL ack_send: tx_dv=%b tx_byte=%h need 1 06", tx_dv, tx_byte);
    end
    @(negedge clk); #1;
    checks++;
    if (tx_dv !== 1'b0 || tx_byte !== 8'h06 || n_tx - tx0 != 1) begin
      errors++; $display("FAIL ack_once: tx_dv=%b tx_byte=%h pulses=%0d need 0 06 1", tx_dv, tx_byte, n_tx - tx0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_good();
    test_csum_err();
    test_noise();
    test_timeout();
    test_timeout_boundary();
    test_mid_reset();
    test_back_to_back();
`ifdef UART_CMD_ACK_EN
    test_ack();
`endif
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
